imm_decode_buffer: RTL and testbench

Parametrised successor to the decode-stage immediate generator. It classifies the instruction format from the opcode and produces one sign-extended XLEN-wide immediate plus a format code. Results are carried through a 2-entry valid/ready skid buffer, so the fetch and execute sides are decoupled and no combinational path exists from out_ready_i to in_ready_o. The block sits between the fetch/decode boundary and the register-read logic, and supports RV32 and RV64.

---
 rtl/imm_decode_buffer.sv | 153 +++++++++++++++
 tb/tb_imm_decode_buffer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/imm_decode_buffer.sv
// Immediate decoder with a 2-entry valid/ready skid buffer.
// Classifies the instruction format from its opcode, builds the sign-extended
// XLEN-wide immediate and carries it, the PC tag and rd through a small FIFO.
// in_ready_o is derived from the registered count only, so there is no
// combinational path from out_ready_i back to in_ready_o.
module imm_decode_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instruction_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      imm_type_o,
  output logic [XLEN-1:0] pc_o,
  output logic [4:0]      rd_o
);

  localparam logic [2:0] T_NONE = 3'd0;
  localparam logic [2:0] T_I    = 3'd1;
  localparam logic [2:0] T_S    = 3'd2;
  localparam logic [2:0] T_B    = 3'd3;
  localparam logic [2:0] T_U    = 3'd4;
  localparam logic [2:0] T_J    = 3'd5;
  localparam logic [2:0] T_ILL  = 3'd7;

  localparam logic [1:0] FULL   = 2'd2;
  localparam bit         RV64   = (XLEN == 64);

  // Opcode -> format class. RV64-only word opcodes fall to illegal on RV32.
  function automatic logic [2:0] decode_type(input logic [6:0] op);
    logic [2:0] t;
    t = T_ILL;
    case (op)
      7'b0000011, 7'b0010011,
      7'b1100111, 7'b1110011: t = T_I;
      7'b0011011:             t = RV64 ? T_I : T_ILL;
      7'b0100011:             t = T_S;
      7'b1100011:             t = T_B;
      7'b0110111, 7'b0010111: t = T_U;
      7'b1101111:             t = T_J;
      7'b0110011:             t = T_NONE;
      7'b0111011:             t = RV64 ? T_NONE : T_ILL;
      default:                t = T_ILL;
    endcase
    return t;
  endfunction

  // Reassemble the 32-bit signed immediate for a given format class.
  function automatic logic signed [31:0] build_imm32(input logic [2:0]  t,
                                                     input logic [31:0] i);
    logic signed [31:0] v;
    v = '0;
    case (t)
      T_I: v = {{20{i[31]}}, i[31:20]};
      T_S: v = {{20{i[31]}}, i[31:25], i[11:7]};
      T_B: v = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      T_U: v = {i[31:12], 12'b0};
      T_J: v = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: v = '0;
    endcase
    return v;
  endfunction

  // Widen a 32-bit signed immediate to XLEN, replicating bit 31.
  function automatic logic signed [XLEN-1:0] sext_xlen(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  // ---- stage p0: combinational decode on the input side ----
  logic                   vld_p0;
  logic [2:0]             type_p0;
  logic signed [31:0]     imm32_p0;
  logic signed [XLEN-1:0] imm_p0;

  assign vld_p0   = in_valid_i;
  assign type_p0  = decode_type(instruction_i[6:0]);
  assign imm32_p0 = build_imm32(type_p0, instruction_i);
  assign imm_p0   = sext_xlen(imm32_p0);

  // ---- stage p1: two-entry storage with wrap-around pointers ----
  logic signed [XLEN-1:0] imm_p1  [DEPTH];
  logic [2:0]             type_p1 [DEPTH];
  logic [XLEN-1:0]        pc_p1   [DEPTH];
  logic [4:0]             rd_p1   [DEPTH];

  logic [1:0] count;
  logic       wr_ptr;
  logic       rd_ptr;
  logic       vld_p1;
  logic       push;
  logic       pop;

  assign vld_p1      = (count != 2'd0);
  assign out_valid_o = vld_p1;
  assign in_ready_o  = (count < FULL);

  // Flush wins over any handshake happening in the same cycle.
  assign push = vld_p0 && in_ready_o && !flush_i;
  assign pop  = vld_p1 && out_ready_i && !flush_i;

  // Control state: occupancy and pointers, cleared by reset or flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (flush_i) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Entry payload: written on push only; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      imm_p1[wr_ptr]  <= imm_p0;
      type_p1[wr_ptr] <= type_p0;
      pc_p1[wr_ptr]   <= pc_i;
      rd_p1[wr_ptr]   <= instruction_i[11:7];
    end
  end

  // Head outputs read zero whenever the buffer is empty, including during reset.
  always_comb begin
    imm_o      = '0;
    imm_type_o = T_NONE;
    pc_o       = '0;
    rd_o       = '0;
    if (vld_p1) begin
      imm_o      = imm_p1[rd_ptr];
      imm_type_o = type_p1[rd_ptr];
      pc_o       = pc_p1[rd_ptr];
      rd_o       = rd_p1[rd_ptr];
    end
  end

endmodule

// File: tb/tb_imm_decode_buffer.sv
// Directed bench for imm_decode_buffer: RV32 and RV64 instances share stimulus.
module tb_imm_decode_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic        in_valid_i;
  logic [31:0] instruction_i;
  logic [31:0] pc32;
  logic [63:0] pc64;
  logic        out_ready_i;

  logic        in_ready_32, out_valid_32;
  logic [31:0] imm_32, pc_o32;
  logic [2:0]  type_32;
  logic [4:0]  rd_32;

  logic        in_ready_64, out_valid_64;
  logic [63:0] imm_64, pc_o64;
  logic [2:0]  type_64;
  logic [4:0]  rd_64;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imm_decode_buffer #(.XLEN(32), .DEPTH(2)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_32),
    .instruction_i(instruction_i), .pc_i(pc32),
    .out_valid_o(out_valid_32), .out_ready_i(out_ready_i),
    .imm_o(imm_32), .imm_type_o(type_32), .pc_o(pc_o32), .rd_o(rd_32)
  );

  imm_decode_buffer #(.XLEN(64), .DEPTH(2)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_64),
    .instruction_i(instruction_i), .pc_i(pc64),
    .out_valid_o(out_valid_64), .out_ready_i(out_ready_i),
    .imm_o(imm_64), .imm_type_o(type_64), .pc_o(pc_o64), .rd_o(rd_64)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    in_valid_i    = v;
    instruction_i = ins;
    pc32          = pc;
    pc64          = {32'h0, pc};
  endtask

  // Check the RV32 head entry.
  task automatic head32(input string tag, input logic [31:0] imm, input logic [2:0] t,
                        input logic [4:0] rd, input logic [31:0] pc);
    check({tag, "_vld"},  {63'h0, out_valid_32}, 64'h1);
    check({tag, "_imm"},  {32'h0, imm_32}, {32'h0, imm});
    check({tag, "_type"}, {61'h0, type_32}, {61'h0, t});
    check({tag, "_rd"},   {59'h0, rd_32}, {59'h0, rd});
    check({tag, "_pc"},   {32'h0, pc_o32}, {32'h0, pc});
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; out_ready_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    #1;
    // Reset state
    check("rst_vld",   {63'h0, out_valid_32}, 64'h0);
    check("rst_rdy",   {63'h0, in_ready_32},  64'h1);
    check("rst_imm",   {32'h0, imm_32}, 64'h0);
    check("rst_type",  {61'h0, type_32}, 64'h0);
    check("rst_pc",    {32'h0, pc_o32}, 64'h0);
    check("rst_rd",    {59'h0, rd_32}, 64'h0);
    check("rst_vld64", {63'h0, out_valid_64}, 64'h0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Test 1: I-type then B-type, consumer always ready
    out_ready_i = 1'b1;
    drive(1'b1, 32'hFFF12083, 32'h100);
    step();
    head32("t1_i", 32'hFFFFFFFF, 3'd1, 5'd1, 32'h100);
    drive(1'b1, 32'hFE000EE3, 32'h104);
    step();
    head32("t1_b", 32'hFFFFFFFC, 3'd3, 5'h1D, 32'h104);

    // Test 2: S, U, J back-to-back
    drive(1'b1, 32'hFE112F23, 32'h108);
    step();
    head32("t2_s", 32'hFFFFFFFE, 3'd2, 5'h1E, 32'h108);
    drive(1'b1, 32'hFFFFF0B7, 32'h10C);
    step();
    head32("t2_u", 32'hFFFFF000, 3'd4, 5'd1, 32'h10C);
    check("t2_u64_imm", imm_64, 64'hFFFFFFFFFFFFF000);
    check("t2_u64_type", {61'h0, type_64}, 64'd4);
    drive(1'b1, 32'hFFFFF0EF, 32'h110);
    step();
    head32("t2_j", 32'hFFFFFFFE, 3'd5, 5'd1, 32'h110);
    check("t2_j64_imm", imm_64, 64'hFFFFFFFFFFFFFFFE);
    drive(1'b0, 32'h0, 32'h0);
    step();
    check("t2_drain_vld", {63'h0, out_valid_32}, 64'h0);
    check("t2_drain_imm", {32'h0, imm_32}, 64'h0);

    // Test 3: backpressure with three instructions
    out_ready_i = 1'b0;
    drive(1'b1, 32'h00500093, 32'h200);
    step();
    head32("t3_a1", 32'd5, 3'd1, 5'd1, 32'h200);
    check("t3_rdy1", {63'h0, in_ready_32}, 64'h1);
    drive(1'b1, 32'h00A00113, 32'h204);
    step();
    check("t3_rdy_full", {63'h0, in_ready_32}, 64'h0);
    head32("t3_a2", 32'd5, 3'd1, 5'd1, 32'h200);
    drive(1'b1, 32'h00F00193, 32'h208);
    step();
    check("t3_rdy_full2", {63'h0, in_ready_32}, 64'h0);
    head32("t3_a3", 32'd5, 3'd1, 5'd1, 32'h200);
    out_ready_i = 1'b1;
    step();
    head32("t3_b", 32'd10, 3'd1, 5'd2, 32'h204);
    check("t3_rdy_after_pop", {63'h0, in_ready_32}, 64'h1);
    step();
    head32("t3_c", 32'd15, 3'd1, 5'd3, 32'h208);
    drive(1'b0, 32'h0, 32'h0);
    step();
    check("t3_empty", {63'h0, out_valid_32}, 64'h0);

    // Test 4: illegal opcode and RV64-only opcode
    drive(1'b1, 32'h0000007F, 32'h300);
    step();
    head32("t4_ill", 32'h0, 3'd7, 5'd0, 32'h300);
    drive(1'b1, 32'h0010009B, 32'h304);
    step();
    head32("t4_w32", 32'h0, 3'd7, 5'd1, 32'h304);
    check("t4_w64_type", {61'h0, type_64}, 64'd1);
    check("t4_w64_imm", imm_64, 64'd1);
    drive(1'b0, 32'h0, 32'h0);
    step();

    // Test 5: flush while full with a concurrent push
    out_ready_i = 1'b0;
    drive(1'b1, 32'h00500093, 32'h400);
    step();
    drive(1'b1, 32'h00A00113, 32'h404);
    step();
    check("t5_full", {63'h0, in_ready_32}, 64'h0);
    flush_i = 1'b1;
    drive(1'b1, 32'h00F00193, 32'h408);
    step();
    flush_i = 1'b0;
    check("t5_flush_vld", {63'h0, out_valid_32}, 64'h0);
    check("t5_flush_rdy", {63'h0, in_ready_32}, 64'h1);
    drive(1'b0, 32'h0, 32'h0);
    out_ready_i = 1'b1;
    step();
    check("t5_no_ghost", {63'h0, out_valid_32}, 64'h0);
    drive(1'b1, 32'h00700213, 32'h40C);
    step();
    head32("t5_fresh", 32'd7, 3'd1, 5'd4, 32'h40C);
    drive(1'b0, 32'h0, 32'h0);
    step();

    // Test 6: asynchronous reset while full
    out_ready_i = 1'b0;
    drive(1'b1, 32'h00500093, 32'h500);
    step();
    drive(1'b1, 32'h00A00113, 32'h504);
    step();
    check("t6_full", {63'h0, in_ready_32}, 64'h0);
    drive(1'b0, 32'h0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_vld", {63'h0, out_valid_32}, 64'h0);
    check("t6_rst_imm", {32'h0, imm_32}, 64'h0);
    check("t6_rst_rdy", {63'h0, in_ready_32}, 64'h1);
    check("t6_rst_imm64", imm_64, 64'h0);
    step();
    rst_n = 1'b1;
    step();
    out_ready_i = 1'b1;
    drive(1'b1, 32'h00800293, 32'h508);
    step();
    head32("t6_fresh", 32'd8, 3'd1, 5'd5, 32'h508);
    drive(1'b0, 32'h0, 32'h0);
    step();
    check("t6_end_vld", {63'h0, out_valid_32}, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
